ir_nec_decoder: RTL and testbench
=================================

# ir_nec_decoder

Decodes the raw demodulated output of the IR receiver into a 16-bit `{address, command}` word for `ir_in` on the graphics top. It sits directly upstream of the VGA controller's `ir_in` port. The block measures mark/space widths with a tick-based counter and walks a NEC-protocol state machine. It holds the last valid code until a new frame is decoded and flags repeat codes and malformed frames with single-cycle pulses.

## Interface
Parameters:
- `TICK_DIV`, default 500: clock cycles per timing tick. 500 at 50 MHz gives a 10 µs tick.
- `TIMEOUT_TICKS`, default 1100: maximum width of any mark or space inside a frame.

Ports:
- `clock`  in  1  system clock.
- `resetn`  in  1  reset. Asynchronous and active-low.
- `ir_rx`  in  1  raw receiver pin, asynchronous. Low means mark (carrier present); the line idles high.
- `ir_code`  out  16  `{address[7:0], command[7:0]}` of the last valid frame.
- `code_valid`  out  1  one-cycle pulse when `ir_code` updates.
- `repeat_pulse`  out  1  one-cycle pulse when a NEC repeat code is received.
- `frame_err`  out  1  one-cycle pulse when a frame is aborted.

## Operation
- **Input conditioning**
  - `ir_rx` passes through a 2-FF synchronizer, then a registered edge detector.
  - A falling edge marks the start of a mark; a rising edge marks the end of a mark.
- **Width counter**
  - The prescaler counts to `TICK_DIV-1`.
  - The 12-bit tick counter saturates at 4095.
  - Both counters clear on every detected edge, so the counter holds the width of the current level in ticks.
- **FSM states:** IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, CHECK.
  - **IDLE:** a falling edge goes to LEAD_MARK. All other input is ignored.
  - **LEAD_MARK:** on a rising edge, a width of 800–1000 goes to LEAD_SPACE; any other width is an error.
  - **LEAD_SPACE:** on a falling edge:
    - width 400–500: clear the bit count and go to BIT_MARK;
    - width 180–270: pulse `repeat_pulse` and go to IDLE;
    - any other width: error.
  - **BIT_MARK:** on a rising edge, a width of 40–75 goes to BIT_SPACE; any other width is an error.
  - **BIT_SPACE:** on a falling edge:
    - width 40–75 shifts in 0; width 140–200 shifts in 1; any other width is an error;
    - bits shift in LSB-first into a 32-bit register;
    - after the 32nd bit go to CHECK, otherwise go to BIT_MARK.
  - **CHECK:** the 32-bit register holds addr = bits[7:0], addr_n = bits[15:8], cmd = bits[23:16], cmd_n = bits[31:24].
    - If `cmd == ~cmd_n`, load `ir_code <= {addr, cmd}` and pulse `code_valid`. `addr_n` is not checked, which supports extended NEC.
    - Otherwise pulse `frame_err`.
    - Go to IDLE in both cases.
- **Timeout:** in any state other than IDLE, a tick count above `TIMEOUT_TICKS` pulses `frame_err` and returns to IDLE.
- **Error handling:** every error pulses `frame_err` for one cycle and returns to IDLE. `ir_code` keeps its previous value.
- **Simultaneous events:** the timeout is evaluated before edge handling in the same cycle.

## Timing
- **Reset values:**
  - `ir_code` = 16'h0000; `code_valid`, `repeat_pulse`, `frame_err` = 0.
  - FSM in IDLE; shift register, bit count, prescaler and tick counter = 0.
- **Reset mid-frame:** the partial frame is discarded. The first falling edge after release starts a fresh frame.
- **Latency:** `code_valid` is high for exactly 1 cycle.
  - It asserts 4 clocks after the falling edge of `ir_rx` that starts the trailing mark: 2 sync + 1 edge register + 1 CHECK.
  - `ir_code` changes in that same cycle.
- **Pulse timing:** `repeat_pulse` and `frame_err` assert 3 clocks after the deciding edge. A timeout error asserts 1 clock after the counter crosses `TIMEOUT_TICKS`.
- **Exclusivity:** at most one of the three pulses is high in any cycle.
- **Width accuracy:** measured widths are accurate to ±1 tick.

## Structure
- **Shared package `ir_nec_pkg`:**
  - FSM state encoding;
  - window constants: LEAD_MARK 800/1000, LEAD_SPACE 400/500, REPEAT_SPACE 180/270, BIT_MARK 40/75, ZERO 40/75, ONE 140/200;
  - counter width (12).
- **Sub-module `ir_pulse_timer`:** synchronizer, edge detector, prescaler and saturating width counter.
  - Outputs: `fall`, `rise`, `width[11:0]`.
- The top level holds the FSM, the shift register and the output registers.

## Test plan
- **Valid frame:** addr 0x00, cmd 0x45, cmd_n 0xBA, nominal timing → one `code_valid` pulse; `ir_code` = 0x0045; no `frame_err`.
- **Bad complement:** as above but cmd_n 0xBB → one `frame_err` pulse; `ir_code` unchanged; no `code_valid`.
- **Repeat code:** valid frame, then 9 ms mark, 2.25 ms space, 560 µs mark → one `repeat_pulse`; `ir_code` stays 0x0045.
- **Short leader:** 6 ms leader mark → `frame_err` 3 clocks after its rising edge; FSM back in IDLE; a following valid frame with addr 0x10, cmd 0x0C decodes to 0x100C.
- **Timeout:** line held high for 20 ms after 10 bits → `frame_err` at 11 ms; no further pulses.
- **Reset mid-frame:** `resetn` low after 16 bits → all outputs 0. A full frame after release decodes normally.

Source files
------------

// File: rtl/ir_nec_pkg.sv
// Shared definitions for the NEC IR decoder: FSM encoding, timing windows
// (in ticks) and the width-counter size.
package ir_nec_pkg;

  localparam int CNT_W = 12;
  localparam logic [CNT_W-1:0] CNT_MAX = 12'd4095;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LEAD_MARK  = 3'd1,
    ST_LEAD_SPACE = 3'd2,
    ST_BIT_MARK   = 3'd3,
    ST_BIT_SPACE  = 3'd4,
    ST_CHECK      = 3'd5
  } nec_state_t;

  // Acceptance windows, inclusive, in ticks
  localparam logic [CNT_W-1:0] LEAD_MARK_MIN    = 12'd800;
  localparam logic [CNT_W-1:0] LEAD_MARK_MAX    = 12'd1000;
  localparam logic [CNT_W-1:0] LEAD_SPACE_MIN   = 12'd400;
  localparam logic [CNT_W-1:0] LEAD_SPACE_MAX   = 12'd500;
  localparam logic [CNT_W-1:0] REPEAT_SPACE_MIN = 12'd180;
  localparam logic [CNT_W-1:0] REPEAT_SPACE_MAX = 12'd270;
  localparam logic [CNT_W-1:0] BIT_MARK_MIN     = 12'd40;
  localparam logic [CNT_W-1:0] BIT_MARK_MAX     = 12'd75;
  localparam logic [CNT_W-1:0] ZERO_MIN         = 12'd40;
  localparam logic [CNT_W-1:0] ZERO_MAX         = 12'd75;
  localparam logic [CNT_W-1:0] ONE_MIN          = 12'd140;
  localparam logic [CNT_W-1:0] ONE_MAX          = 12'd200;

  function automatic logic in_window(input logic [CNT_W-1:0] w,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (w >= lo) && (w <= hi);
  endfunction

endpackage

// File: rtl/ir_pulse_timer.sv
// Input conditioning for the IR line: 2-FF synchronizer, edge detector and a
// tick-based saturating counter that measures the width of the current level.
module ir_pulse_timer
  import ir_nec_pkg::*;
#(
  parameter int TICK_DIV = 500
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             ir_rx,
  output logic             fall,
  output logic             rise,
  output logic [CNT_W-1:0] width
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_prev;
  logic [PW-1:0]   r_presc;
  logic [CNT_W-1:0] r_width;
  logic            w_edge;
  logic            w_tick;

  // Synchronize the asynchronous pin and keep one delayed copy; the line
  // idles high so reset to 1 to avoid a spurious edge after reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= ir_rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign fall   = r_prev & ~r_sync2;
  assign rise   = ~r_prev & r_sync2;
  assign w_edge = fall | rise;
  assign w_tick = (r_presc == PRESC_LAST);
  assign width  = r_width;

  // Prescaler plus saturating tick counter, both restarted on every edge
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_presc <= '0;
      r_width <= '0;
    end else if (w_edge) begin
      r_presc <= '0;
      r_width <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick && (r_width != CNT_MAX)) r_width <= r_width + 1'b1;
    end
  end

endmodule

// File: rtl/ir_nec_decoder.sv
// NEC IR frame decoder: walks leader / 32 data bits / check, holds the last
// valid {address, command} and pulses code_valid, repeat_pulse or frame_err.
module ir_nec_decoder
  import ir_nec_pkg::*;
#(
  parameter int TICK_DIV      = 500,
  parameter int TIMEOUT_TICKS = 1100
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        ir_rx,
  output logic [15:0] ir_code,
  output logic        code_valid,
  output logic        repeat_pulse,
  output logic        frame_err,
  output logic [2:0]  o_dbg_state
);

  localparam logic [CNT_W-1:0] TIMEOUT_W = CNT_W'(TIMEOUT_TICKS);

  logic             w_fall;
  logic             w_rise;
  logic [CNT_W-1:0] w_width;
  logic             w_timeout;
  logic             w_is_zero;
  logic             w_is_one;
  logic [7:0]       w_addr;
  logic [7:0]       w_cmd;
  logic [7:0]       w_cmd_n;

  nec_state_t  r_state;
  logic [31:0] r_shift;
  logic [4:0]  r_bitcnt;
  logic [15:0] r_code;
  logic        r_valid;
  logic        r_rep;
  logic        r_err;

  ir_pulse_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clock  (clock),
    .resetn (resetn),
    .ir_rx  (ir_rx),
    .fall   (w_fall),
    .rise   (w_rise),
    .width  (w_width)
  );

  assign w_timeout = (r_state != ST_IDLE) && (w_width > TIMEOUT_W);
  assign w_is_zero = in_window(w_width, ZERO_MIN, ZERO_MAX);
  assign w_is_one  = in_window(w_width, ONE_MIN, ONE_MAX);
  assign w_addr    = r_shift[7:0];
  assign w_cmd     = r_shift[23:16];
  assign w_cmd_n   = r_shift[31:24];

  // Protocol FSM; timeout has priority over any edge seen in the same cycle.
  // The address complement byte is deliberately ignored (extended NEC).
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_code   <= '0;
      r_valid  <= 1'b0;
      r_rep    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_rep   <= 1'b0;
      r_err   <= 1'b0;
      if (w_timeout) begin
        r_err   <= 1'b1;
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_fall) r_state <= ST_LEAD_MARK;
          end
          ST_LEAD_MARK: begin
            if (w_rise) begin
              if (in_window(w_width, LEAD_MARK_MIN, LEAD_MARK_MAX)) begin
                r_state <= ST_LEAD_SPACE;
              end else begin
                r_err   <= 1'b1;
                r_state <= ST_IDLE;
              end
            end
          end
          ST_LEAD_SPACE: begin
            if (w_fall) begin
              if (in_window(w_width, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
                r_bitcnt <= '0;
                r_state  <= ST_BIT_MARK;
              end else if (in_window(w_width, REPEAT_SPACE_MIN, REPEAT_SPACE_MAX)) begin
                r_rep   <= 1'b1;
                r_state <= ST_IDLE;
              end else begin
                r_err   <= 1'b1;
                r_state <= ST_IDLE;
              end
            end
          end
          ST_BIT_MARK: begin
            if (w_rise) begin
              if (in_window(w_width, BIT_MARK_MIN, BIT_MARK_MAX)) begin
                r_state <= ST_BIT_SPACE;
              end else begin
                r_err   <= 1'b1;
                r_state <= ST_IDLE;
              end
            end
          end
          ST_BIT_SPACE: begin
            if (w_fall) begin
              if (w_is_zero || w_is_one) begin
                r_shift  <= {w_is_one, r_shift[31:1]};
                r_bitcnt <= r_bitcnt + 1'b1;
                r_state  <= (r_bitcnt == 5'd31) ? ST_CHECK : ST_BIT_MARK;
              end else begin
                r_err   <= 1'b1;
                r_state <= ST_IDLE;
              end
            end
          end
          ST_CHECK: begin
            if (w_cmd == ~w_cmd_n) begin
              r_code  <= {w_addr, w_cmd};
              r_valid <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign ir_code      = r_code;
  assign code_valid   = r_valid;
  assign repeat_pulse = r_rep;
  assign frame_err    = r_err;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_ir_nec_decoder.sv
// Directed + randomized bench for ir_nec_decoder. One tick per clock keeps
// full NEC frames short enough to simulate many of them.
module tb_ir_nec_decoder;
  import ir_nec_pkg::*;

  localparam int TICK_DIV      = 1;
  localparam int TIMEOUT_TICKS = 1100;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        resetn;
  logic        ir_rx;
  logic [15:0] ir_code;
  logic        code_valid;
  logic        repeat_pulse;
  logic        frame_err;
  logic [2:0]  o_dbg_state;

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  ir_nec_decoder #(.TICK_DIV(TICK_DIV), .TIMEOUT_TICKS(TIMEOUT_TICKS)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .ir_rx        (ir_rx),
    .ir_code      (ir_code),
    .code_valid   (code_valid),
    .repeat_pulse (repeat_pulse),
    .frame_err    (frame_err),
    .o_dbg_state  (o_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int n_valid = 0, n_rep = 0, n_err = 0, n_overlap = 0;
  int unsigned last_valid_cyc = 0, last_rep_cyc = 0, last_err_cyc = 0;
  logic [15:0] obs_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] exp_code;
  int unsigned t_stamp;

  // Monitor: record every output pulse away from the active edge
  always @(negedge clock) begin
    if (code_valid === 1'b1) begin
      n_valid++;
      last_valid_cyc = cyc;
      obs_q.push_back(ir_code);
    end
    if (repeat_pulse === 1'b1) begin
      n_rep++;
      last_rep_cyc = cyc;
    end
    if (frame_err === 1'b1) begin
      n_err++;
      last_err_cyc = cyc;
    end
    if ((32'(code_valid) + 32'(repeat_pulse) + 32'(frame_err)) > 32'd1) n_overlap++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Hold the line at lvl for len ticks (one tick = one clock here)
  task automatic drive_level(input logic lvl, input int len);
    ir_rx = lvl;
    repeat (len) @(negedge clock);
  endtask

  // Send leader + nbits data bits (LSB first); with 32 bits also send the
  // trailing mark and record when its falling edge was driven.
  task automatic send_frame(input logic [31:0] bits, input int nbits, input bit rnd);
    int lm, ls, bm, sp;
    lm = rnd ? int'($urandom_range(980, 820)) : 900;
    ls = rnd ? int'($urandom_range(490, 410)) : 450;
    drive_level(1'b0, lm);
    drive_level(1'b1, ls);
    for (int i = 0; i < nbits; i++) begin
      bm = rnd ? int'($urandom_range(70, 45)) : 56;
      if (bits[i]) sp = rnd ? int'($urandom_range(190, 150)) : 169;
      else         sp = rnd ? int'($urandom_range(70, 45)) : 56;
      drive_level(1'b0, bm);
      drive_level(1'b1, sp);
    end
    if (nbits == 32) begin
      t_stamp = cyc;
      drive_level(1'b0, 56);
      drive_level(1'b1, 300);
    end
  endtask

  // Reference model: a frame is good when cmd is the bitwise inverse of cmd_n
  task automatic run_frame(input string tag, input logic [31:0] bits, input bit rnd);
    int v0, e0, r0;
    bit ok;
    v0 = n_valid;
    e0 = n_err;
    r0 = n_rep;
    ok = (bits[23:16] == ~bits[31:24]);
    if (ok) begin
      exp_code = {bits[7:0], bits[23:16]};
      exp_q.push_back(exp_code);
    end
    send_frame(bits, 32, rnd);
    check({tag, "_valid_cnt"}, n_valid - v0, ok ? 1 : 0);
    check({tag, "_err_cnt"}, n_err - e0, ok ? 0 : 1);
    check({tag, "_rep_cnt"}, n_rep - r0, 0);
    if (ok) check({tag, "_valid_lat"}, last_valid_cyc - t_stamp, 4);
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check({tag, "_code"}, obs_q.pop_front(), exp_q.pop_front());
    check({tag, "_exp_left"}, exp_q.size(), 0);
    check({tag, "_obs_left"}, obs_q.size(), 0);
    exp_q.delete();
    obs_q.delete();
    check({tag, "_ir_code"}, ir_code, exp_code);
  endtask

  // Watchdog so the run always ends
  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int v0, e0, r0;
    logic [31:0] bits;
    logic [7:0]  a, c;

    resetn   = 1'b0;
    ir_rx    = 1'b1;
    exp_code = 16'h0000;
    repeat (4) @(negedge clock);
    check("rst_ir_code", ir_code, 16'h0000);
    check("rst_code_valid", code_valid, 1'b0);
    check("rst_repeat", repeat_pulse, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_state", o_dbg_state, 32'(ST_IDLE));
    resetn = 1'b1;
    drive_level(1'b1, 20);

    // Valid frame addr 00 cmd 45
    run_frame("valid", {8'hBA, 8'h45, 8'hFF, 8'h00}, 1'b0);

    // Bad command complement
    run_frame("badcmp", {8'hBB, 8'h45, 8'hFF, 8'h00}, 1'b0);

    // Repeat code
    v0 = n_valid; e0 = n_err; r0 = n_rep;
    drive_level(1'b0, 900);
    drive_level(1'b1, 225);
    t_stamp = cyc;
    drive_level(1'b0, 56);
    drive_level(1'b1, 300);
    check("repeat_cnt", n_rep - r0, 1);
    check("repeat_lat", last_rep_cyc - t_stamp, 3);
    check("repeat_valid_cnt", n_valid - v0, 0);
    check("repeat_err_cnt", n_err - e0, 0);
    check("repeat_ir_code", ir_code, 16'h0045);

    // Short leader, then a good frame
    v0 = n_valid; e0 = n_err; r0 = n_rep;
    drive_level(1'b0, 600);
    t_stamp = cyc;
    drive_level(1'b1, 300);
    check("short_err_cnt", n_err - e0, 1);
    check("short_err_lat", last_err_cyc - t_stamp, 3);
    check("short_state", o_dbg_state, 32'(ST_IDLE));
    check("short_valid_cnt", n_valid - v0, 0);
    run_frame("after_short", {~8'h0C, 8'h0C, ~8'h10, 8'h10}, 1'b0);

    // Timeout: 10 bits, a bit mark, then line held high
    v0 = n_valid; e0 = n_err; r0 = n_rep;
    send_frame({8'h00, 8'h00, 8'hFF, 8'h55}, 10, 1'b0);
    drive_level(1'b0, 56);
    t_stamp = cyc;
    drive_level(1'b1, 2000);
    check("tmo_err_cnt", n_err - e0, 1);
    check("tmo_err_lat_lo", ((last_err_cyc - t_stamp) >= 1102) ? 1 : 0, 1);
    check("tmo_err_lat_hi", ((last_err_cyc - t_stamp) <= 1108) ? 1 : 0, 1);
    check("tmo_valid_cnt", n_valid - v0, 0);
    check("tmo_rep_cnt", n_rep - r0, 0);
    check("tmo_ir_code", ir_code, exp_code);
    check("tmo_state", o_dbg_state, 32'(ST_IDLE));

    // Reset in the middle of a frame
    send_frame({8'hF3, 8'h0C, 8'hEF, 8'h10}, 16, 1'b0);
    resetn = 1'b0;
    exp_code = 16'h0000;
    repeat (3) @(negedge clock);
    check("midrst_ir_code", ir_code, 16'h0000);
    check("midrst_valid", code_valid, 1'b0);
    check("midrst_repeat", repeat_pulse, 1'b0);
    check("midrst_err", frame_err, 1'b0);
    check("midrst_state", o_dbg_state, 32'(ST_IDLE));
    ir_rx = 1'b1;
    @(negedge clock);
    resetn = 1'b1;
    drive_level(1'b1, 50);
    run_frame("after_rst", {8'h7E, 8'h81, 8'hD5, 8'h2A}, 1'b0);

    // Randomized frames with jittered widths
    for (int k = 0; k < 4; k++) begin
      a = 8'($urandom);
      c = 8'($urandom);
      bits = {($urandom_range(1, 0) == 1) ? ~c : 8'($urandom), c, 8'($urandom), a};
      run_frame("rand", bits, 1'b1);
    end

    check("pulse_overlap", n_overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
